// File: rtl/crossing_request_unit_if.sv
// Signals between the crossing request unit, the board button/lamp pins and the
// crossing controller.
interface crossing_request_unit_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               button;
  logic [4:0]         lightseq;
  logic               start;
  logic               wait_lamp;
  logic [COUNT_W-1:0] served_count;
  logic               seq_error;

  modport master (
    output button, lightseq,
    input  start, wait_lamp, served_count, seq_error
  );
  modport slave (
    input  button, lightseq,
    output start, wait_lamp, served_count, seq_error
  );
endinterface

// File: rtl/crossing_request_unit.sv
// Pedestrian request unit: button sync/debounce, start/WAIT handshake with the
// crossing controller, served counter and light-sequence protocol monitor.
module crossing_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_W         = 8
) (
  input logic                    clock,
  input logic                    reset,
  crossing_request_unit_if.slave bus
);
  localparam logic [4:0] CodeRg   = 5'b01001;
  localparam logic [4:0] CodeRa   = 5'b01010;
  localparam logic [4:0] CodeWalk = 5'b10100;
  localparam logic [4:0] CodeRra  = 5'b01110;
  localparam logic [3:0] DbLast   = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPending, StServing} state_e;

  logic               sync1_q, btn_s_q, btn_db_q, btn_db_dly_q;
  logic [3:0]         db_cnt_q;
  state_e             state_q, state_d;
  logic               pend_again_q, pend_again_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               start_q, wait_q;
  logic [4:0]         prev_code_q;
  logic               prev_valid_q;
  logic               seq_error_q, seq_error_d;
  logic               press, walk, code_legal, trans_legal;

  assign press = btn_db_q & ~btn_db_dly_q;
  assign walk  = (bus.lightseq == CodeWalk);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      btn_db_dly_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= bus.button;
      btn_s_q      <= sync1_q;
      btn_db_dly_q <= btn_db_q;
      if (btn_s_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        btn_db_q <= btn_s_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_again_d = pend_again_q;
    count_d      = count_q;
    unique case (state_q)
      StIdle: begin
        if (press) state_d = StPending;
      end
      StPending: begin
        // WALK wins over a coincident press; the press is dropped.
        if (walk) begin
          state_d = StServing;
          count_d = count_q + 1'b1;
        end
      end
      StServing: begin
        if (press) pend_again_d = 1'b1;
        if (!walk) begin
          state_d      = (pend_again_q || press) ? StPending : StIdle;
          pend_again_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    code_legal  = bus.lightseq inside {CodeRg, CodeRa, CodeWalk, CodeRra};
    trans_legal = 1'b0;
    case (prev_code_q)
      CodeRg:   trans_legal = (bus.lightseq == CodeRg) || (bus.lightseq == CodeRa);
      CodeRa:   trans_legal = (bus.lightseq == CodeWalk);
      CodeWalk: trans_legal = (bus.lightseq == CodeWalk) || (bus.lightseq == CodeRra);
      CodeRra:  trans_legal = (bus.lightseq == CodeRg);
      default:  trans_legal = 1'b0;
    endcase
    seq_error_d = seq_error_q | ~code_legal | (prev_valid_q & ~trans_legal);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_again_q <= 1'b0;
      count_q      <= '0;
      start_q      <= 1'b0;
      wait_q       <= 1'b0;
      prev_code_q  <= '0;
      prev_valid_q <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_again_q <= pend_again_d;
      count_q      <= count_d;
      start_q      <= (state_d == StPending);
      wait_q       <= (state_d == StPending);
      prev_code_q  <= bus.lightseq;
      prev_valid_q <= 1'b1;
      seq_error_q  <= seq_error_d;
    end
  end

  assign bus.start        = start_q;
  assign bus.wait_lamp    = wait_q;
  assign bus.served_count = count_q;
  assign bus.seq_error    = seq_error_q;
endmodule

// File: tb/tb_crossing_request_unit.sv
// Scoreboard bench: a behavioural model predicts outputs per cycle into a queue,
// and an independent monitor pops and compares against the DUT.
module tb_crossing_request_unit;
  localparam int unsigned Deb = 4;
  localparam int unsigned Cw  = 2;
  localparam logic [4:0] RG   = 5'b01001;
  localparam logic [4:0] RA   = 5'b01010;
  localparam logic [4:0] WALK = 5'b10100;
  localparam logic [4:0] RRA  = 5'b01110;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  crossing_request_unit_if #(.COUNT_W(Cw)) bus ();
  crossing_request_unit #(.DEBOUNCE_CYCLES(Deb), .COUNT_W(Cw)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic          start;
    logic          wait_lamp;
    logic [Cw-1:0] count;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic btn_level = 1'b0;

  logic [9:0] allowed [6] = '{{RG, RG}, {RG, RA}, {RA, WALK}, {WALK, WALK}, {WALK, RRA},
                              {RRA, RG}};

  // Reference model state: sampled button history, request/walk flags, totals.
  logic m_s1, m_s2, m_db, m_dbd;
  int   m_run, m_served;
  bit   m_req, m_walking, m_again, m_err, m_pv;
  logic [4:0] m_prev;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] c);
    return c inside {RG, RA, WALK, RRA};
  endfunction

  function automatic bit pair_ok(input logic [4:0] p, input logic [4:0] c);
    foreach (allowed[i]) if (allowed[i] == {p, c}) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbd = 0; m_run = 0; m_served = 0;
    m_req = 0; m_walking = 0; m_again = 0; m_err = 0; m_pv = 0; m_prev = '0;
  endtask

  task automatic model_step(input logic b, input logic [4:0] ls);
    bit   press;
    bit   walk;
    exp_t e;
    if (reset) begin
      model_clear();
    end else begin
      press = m_db && !m_dbd;
      walk  = (ls == WALK);
      m_dbd = m_db;
      if (m_s2 == m_db) m_run = 0;
      else if (m_run + 1 == Deb) begin m_db = m_s2; m_run = 0; end
      else m_run++;
      m_s2 = m_s1;
      m_s1 = b;
      if (m_walking) begin
        if (press) m_again = 1;
        if (!walk) begin m_walking = 0; m_req = m_again; m_again = 0; end
      end else if (m_req) begin
        if (walk) begin m_req = 0; m_walking = 1; m_served++; end
      end else if (press) begin
        m_req = 1;
      end
      if (!is_legal(ls) || (m_pv && !pair_ok(m_prev, ls))) m_err = 1;
      m_prev = ls;
      m_pv   = 1;
    end
    e.start     = m_req;
    e.wait_lamp = m_req;
    e.count     = m_served[Cw-1:0];
    e.err       = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic b, input logic [4:0] ls);
    @(negedge clock);
    bus.button   = b;
    bus.lightseq = ls;
    @(posedge clock);
    #1 model_step(b, ls);
  endtask

  task automatic rand_cycle(input logic [4:0] ls);
    if ($urandom_range(0, 5) == 0) btn_level = ~btn_level;
    cycle(btn_level, ls);
  endtask

  task automatic async_reset_check();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("async_start", int'(bus.start), 0);
    check("async_wait", int'(bus.wait_lamp), 0);
    check("async_count", int'(bus.served_count), 0);
    check("async_err", int'(bus.seq_error), 0);
    exp_q.delete();
    model_clear();
    cycle(1'b0, RG);
    cycle(1'b0, RG);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("start", int'(bus.start), int'(e.start));
        check("wait_lamp", int'(bus.wait_lamp), int'(e.wait_lamp));
        check("served_count", int'(bus.served_count), int'(e.count));
        check("seq_error", int'(bus.seq_error), int'(e.err));
      end
    end
  end

  initial begin : stimulus
    bit got;
    model_clear();
    bus.button   = 1'b0;
    bus.lightseq = RG;
    cycle(1'b0, RG);
    cycle(1'b0, RG);
    reset = 1'b0;
    repeat (20) cycle(1'b0, RG);

    // Short pulse is rejected, long press raises start after debounce latency.
    repeat (3) cycle(1'b1, RG);
    repeat (6) cycle(1'b0, RG);
    repeat (9) cycle(1'b1, RG);
    repeat (3) cycle(1'b0, RG);

    // Serve once, then press during WALK so RRA re-enters pending.
    cycle(1'b0, RG); cycle(1'b0, RA);
    repeat (3) cycle(1'b0, WALK);
    cycle(1'b0, RRA); cycle(1'b0, RG);
    cycle(1'b0, RA);
    repeat (9) cycle(1'b1, WALK);
    repeat (3) cycle(1'b0, WALK);
    cycle(1'b0, RRA); cycle(1'b0, RG); cycle(1'b0, RG); cycle(1'b0, RA);
    repeat (2) cycle(1'b0, WALK);
    cycle(1'b0, RRA); cycle(1'b0, RG);

    // Illegal code, sticky error, async clear, then an illegal jump.
    cycle(1'b0, 5'b00000);
    repeat (4) cycle(1'b0, RG);
    async_reset_check();
    cycle(1'b0, RG); cycle(1'b0, WALK);
    repeat (3) cycle(1'b0, RG);

    // Reset while a request is pending.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1'b1, RG);
      if (bus.start === 1'b1) got = 1'b1;
    end
    check("pending_reached", int'(got), 1);
    async_reset_check();
    repeat (3) cycle(1'b0, RG);

    // Randomised button against a legal controller sequence; counter wraps.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(2, 8)) rand_cycle(RG);
      repeat ($urandom_range(1, 3)) rand_cycle(RA);
      repeat ($urandom_range(1, 6)) rand_cycle(WALK);
      repeat ($urandom_range(1, 3)) rand_cycle(RRA);
    end
    cycle(1'b0, RG);

    repeat (2) @(posedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
